// File: rtl/accumulate_sequencer.sv
// Control FSM for the switch-accumulate datapath: conditions the button requests and
// sequences B-operand load, adder settle and accumulator write-back.
`timescale 1ns/1ps
module accumulate_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run_Accumulate,
   input  logic       Clear,
   input  logic       Cout,
   output logic       Ld_B,
   output logic       Ld_Acc,
   output logic       Clr_Acc,
   output logic       Busy,
   output logic       Done,
   output logic       Overflow,
   output logic [7:0] Count
);

   localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSettle,
      StWrite,
      StDone,
      StClear
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] settle_q;
   logic       run_s1_q, run_s2_q, run_s3_q;
   logic       clr_s1_q, clr_s2_q, clr_s3_q;
   logic       run_rise, clear_rise;

   // s3 is the delayed copy of the synchronized level used for edge detection
   assign run_rise   = run_s2_q & ~run_s3_q;
   assign clear_rise = clr_s2_q & ~clr_s3_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (clear_rise)    state_d = StClear;
            else if (run_rise) state_d = StLoad;
         end
         StLoad:  state_d = clear_rise ? StClear : StSettle;
         StSettle: begin
            if (clear_rise)            state_d = StClear;
            else if (settle_q <= 4'd1) state_d = StWrite;
         end
         StWrite: state_d = clear_rise ? StClear : StDone;
         StDone:  state_d = clear_rise ? StClear : StIdle;
         StClear: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= StIdle;
         settle_q <= 4'd0;
         run_s1_q <= 1'b0;
         run_s2_q <= 1'b0;
         run_s3_q <= 1'b0;
         clr_s1_q <= 1'b0;
         clr_s2_q <= 1'b0;
         clr_s3_q <= 1'b0;
         Ld_B     <= 1'b0;
         Ld_Acc   <= 1'b0;
         Clr_Acc  <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Overflow <= 1'b0;
         Count    <= 8'd0;
      end else begin
         run_s1_q <= Run_Accumulate;
         run_s2_q <= run_s1_q;
         run_s3_q <= run_s2_q;
         clr_s1_q <= Clear;
         clr_s2_q <= clr_s1_q;
         clr_s3_q <= clr_s2_q;

         state_q <= state_d;

         if (state_q == StLoad) begin
            settle_q <= SettleInit;
         end else if (state_q == StSettle) begin
            settle_q <= settle_q - 4'd1;
         end

         // A write-back aborted by Clear still commits; CLEAR zeroes it right after
         if (state_q == StWrite) begin
            Overflow <= Overflow | Cout;
            Count    <= Count + 8'd1;
         end else if (state_q == StClear) begin
            Overflow <= 1'b0;
            Count    <= 8'd0;
         end

         // Outputs registered from the next state so they track the state register exactly
         Ld_B    <= (state_d == StLoad);
         Ld_Acc  <= (state_d == StWrite);
         Clr_Acc <= (state_d == StClear);
         Done    <= (state_d == StDone);
         Busy    <= (state_d != StIdle);
      end
   end

endmodule
